// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types, seven-segment patterns (active-low, bit0 = a,
//               bit6 = g) and a constant helper that turns a binary value into
//               packed BCD for terminal-count compares.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Converts a binary value (< 10^8) into eight packed BCD digits.
  function automatic logic [31:0] mod_to_bcd(input int value);
    int          v;
    logic [31:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v           = v / 10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ssd_decoder
// Description : BCD digit plus blank flag to active-low seven-segment pattern.
//               Codes above 9 show blank.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_decoder
  import ssd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pattern lookup; blank request overrides the digit value.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_timer
// Description : Parametrised multi-digit BCD up/down timer with run/stop,
//               clear, wrap pulse and a time-multiplexed seven-segment driver.
//               Optional macro SSD_LZB_EN enables leading-zero blanking of the
//               displayed digits (the bcd output is never affected).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_timer
  import ssd_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 200_000,
  parameter int NUM_DIGITS = 2,
  parameter int MOD        = 60
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    clear,
  input  logic                    up_down,
  output logic [NUM_DIGITS-1:0]   A,
  output logic [6:0]              C,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    wrap
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int SDV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0]        PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [SDV_W-1:0]        SDV_LAST = SDV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [31:0]             MAX_ALL  = mod_to_bcd(MOD - 1);
  localparam logic [4*NUM_DIGITS-1:0] MAX_BCD  = MAX_ALL[4*NUM_DIGITS-1:0];

  // Reject parameter sets the counters cannot represent.
  if (CLK_HZ < 1 || TICK_DIV < 2 || SCAN_DIV < 2 || NUM_DIGITS < 1 ||
      NUM_DIGITS > 8 || MOD < 2 || MOD > 10 ** NUM_DIGITS) begin : g_param_check
    $error("ssd_scan_timer: illegal parameter combination");
  end

  logic [PRE_W-1:0]        pre_q,  pre_d;
  logic [SDV_W-1:0]        sdiv_q, sdiv_d;
  logic [IDX_W-1:0]        idx_q,  idx_d;
  logic [4*NUM_DIGITS-1:0] bcd_q,  bcd_d;
  logic                    wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0]   a_q,    a_d;
  logic [6:0]              c_q,    c_d;

  logic                    tick;
  logic [4*NUM_DIGITS-1:0] cnt_up, cnt_dn;
  logic [NUM_DIGITS-1:0]   lzb;
  bcd_digit_t              digit_sel;
  logic                    blank_sel;
  logic [6:0]              seg_w;

  // Prescaler: advances only while running; clear forces it back to zero.
  always_comb begin
    tick  = run && !clear && (pre_q == PRE_LAST);
    pre_d = pre_q;
    if (clear) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    end
  end

  // Per-digit ripple increment/decrement, then terminal wrap and clear priority.
  always_comb begin : p_count_next
    logic carry;
    logic borrow;
    carry  = 1'b1;
    borrow = 1'b1;
    cnt_up = bcd_q;
    cnt_dn = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          cnt_up[4*i +: 4] = 4'd0;
        end else begin
          cnt_up[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          carry            = 1'b0;
        end
      end
      if (borrow) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          cnt_dn[4*i +: 4] = 4'd9;
        end else begin
          cnt_dn[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          borrow           = 1'b0;
        end
      end
    end

    bcd_d  = bcd_q;
    wrap_d = 1'b0;
    if (clear) begin
      bcd_d = '0;
    end else if (tick) begin
      if (up_down) begin
        if (bcd_q == MAX_BCD) begin
          bcd_d  = '0;
          wrap_d = 1'b1;
        end else begin
          bcd_d = cnt_up;
        end
      end else begin
        if (bcd_q == '0) begin
          bcd_d  = MAX_BCD;
          wrap_d = 1'b1;
        end else begin
          bcd_d = cnt_dn;
        end
      end
    end
  end

  // Free-running scan divider stepping the digit index.
  always_comb begin
    sdiv_d = sdiv_q + SDV_W'(1);
    idx_d  = idx_q;
    if (sdiv_q == SDV_LAST) begin
      sdiv_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef SSD_LZB_EN
  // A digit above position 0 blanks when it and every higher digit are zero.
  always_comb begin : p_lzb
    logic zero_above;
    zero_above = 1'b1;
    lzb        = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (bcd_q[4*i +: 4] == 4'd0);
      lzb[i]     = zero_above;
    end
  end
`else
  assign lzb = '0;
`endif

  // Digit mux and anode pattern for the currently scanned position.
  always_comb begin
    digit_sel = '0;
    blank_sel = 1'b0;
    a_d       = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        digit_sel = bcd_q[4*i +: 4];
        blank_sel = lzb[i];
        a_d[i]    = 1'b0;
      end
    end
    c_d = seg_w;
  end

  ssd_decoder u_decoder (
    .digit (digit_sel),
    .blank (blank_sel),
    .seg   (seg_w)
  );

  // State and output registers; anode and segments share one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_q  <= '0;
      sdiv_q <= '0;
      idx_q  <= '0;
      bcd_q  <= '0;
      wrap_q <= 1'b0;
      a_q    <= '1;
      c_q    <= SEG_BLANK;
    end else begin
      pre_q  <= pre_d;
      sdiv_q <= sdiv_d;
      idx_q  <= idx_d;
      bcd_q  <= bcd_d;
      wrap_q <= wrap_d;
      a_q    <= a_d;
      c_q    <= c_d;
    end
  end

  assign A    = a_q;
  assign C    = c_q;
  assign bcd  = bcd_q;
  assign wrap = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_timer
// Description : Directed bench for ssd_scan_timer (4 digits, modulus 60,
//               tick every 4 clocks, scan every 2 clocks). An integer model
//               predicts every output register each edge; predictions queue
//               up and are compared just after the edge. Honours SSD_LZB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_timer;

  localparam int TD = 4;
  localparam int SD = 2;
  localparam int ND = 4;
  localparam int MD = 60;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic        up_down = 1'b1;
  logic [3:0]  a_o;
  logic [6:0]  c_o;
  logic [15:0] bcd_o;
  logic        wrap_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] bcd;
    logic        wrap;
    logic [3:0]  a;
    logic [6:0]  c;
  } exp_t;

  exp_t sb_q[$];

  int m_cnt = 0;
  int m_pre = 0;
  int m_idx = 0;
  int m_sdiv = 0;

  ssd_scan_timer #(
    .CLK_HZ     (100),
    .TICK_DIV   (TD),
    .SCAN_DIV   (SD),
    .NUM_DIGITS (ND),
    .MOD        (MD)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .clear   (clear),
    .up_down (up_down),
    .A       (a_o),
    .C       (c_o),
    .bcd     (bcd_o),
    .wrap    (wrap_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int cnt, input int pos);
    int p;
    int d;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    d = (cnt / p) % 10;
`ifdef SSD_LZB_EN
    if (pos > 0 && cnt < p) return 7'b1111111;
`endif
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // Predict the register contents produced by the edge just taken.
  task automatic model_step();
    exp_t e;
    e.wrap = 1'b0;
    if (reset) begin
      m_cnt = 0; m_pre = 0; m_idx = 0; m_sdiv = 0;
      e.a = 4'b1111;
      e.c = 7'b1111111;
    end else begin
      e.a = ~(4'b0001 << m_idx);
      e.c = exp_seg(m_cnt, m_idx);
      if (m_sdiv == SD - 1) begin
        m_sdiv = 0;
        m_idx  = (m_idx + 1) % ND;
      end else begin
        m_sdiv++;
      end
      if (clear) begin
        m_cnt = 0;
        m_pre = 0;
      end else if (run) begin
        if (m_pre == TD - 1) begin
          m_pre = 0;
          if (up_down) begin
            e.wrap = (m_cnt == MD - 1);
            m_cnt  = (m_cnt + 1) % MD;
          end else begin
            e.wrap = (m_cnt == 0);
            m_cnt  = (m_cnt + MD - 1) % MD;
          end
        end else begin
          m_pre++;
        end
      end
    end
    e.bcd = to_bcd(m_cnt);
    sb_q.push_back(e);
  endtask

  // One clock: predict at the edge, compare the DUT 1 ns later.
  task automatic cyc(input int n = 1);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      model_step();
      #1;
      e = sb_q.pop_front();
      chk("sb_bcd",  {16'h0, bcd_o},  {16'h0, e.bcd});
      chk("sb_wrap", {31'h0, wrap_o}, {31'h0, e.wrap});
      chk("sb_A",    {28'h0, a_o},    {28'h0, e.a});
      chk("sb_C",    {25'h0, c_o},    {25'h0, e.c});
    end
  endtask

  initial begin
    // Reset state
    cyc(2);
    chk("reset_A",    {28'h0, a_o},    32'hF);
    chk("reset_C",    {25'h0, c_o},    32'h7F);
    chk("reset_bcd",  {16'h0, bcd_o},  32'h0);
    chk("reset_wrap", {31'h0, wrap_o}, 32'h0);

    // First cycle after reset release shows digit 0 = "0"
    reset = 1'b0;
    cyc();
    chk("first_A", {28'h0, a_o}, 32'h0000_000E);
    chk("first_C", {25'h0, c_o}, 32'h0000_0040);

    // Full count-up lap: 60 ticks end at 00 with wrap
    run = 1'b1; up_down = 1'b1;
    cyc(240);
    chk("lap_bcd",  {16'h0, bcd_o},  32'h0);
    chk("lap_wrap", {31'h0, wrap_o}, 32'h1);

    // Count down from 00 wraps to 59, then 58
    up_down = 1'b0;
    cyc(4);
    chk("down_wrap_bcd", {16'h0, bcd_o},  32'h59);
    chk("down_wrap",     {31'h0, wrap_o}, 32'h1);
    cyc(4);
    chk("down_bcd", {16'h0, bcd_o}, 32'h58);

    // Run gap with pre=2: hold, then tick 2 clocks after run returns
    cyc(2);
    run = 1'b0;
    cyc(10);
    chk("gap_hold", {16'h0, bcd_o}, 32'h58);
    run = 1'b1;
    cyc();
    chk("gap_1clk", {16'h0, bcd_o}, 32'h58);
    cyc();
    chk("gap_2clk", {16'h0, bcd_o}, 32'h57);

    // Down to 37, then clear on the tick cycle
    cyc(80);
    chk("at_37", {16'h0, bcd_o}, 32'h37);
    cyc(3);
    clear = 1'b1;
    cyc();
    chk("clear_bcd",  {16'h0, bcd_o},  32'h0);
    chk("clear_wrap", {31'h0, wrap_o}, 32'h0);
    clear = 1'b0; up_down = 1'b1;
    cyc(3);
    chk("clear_pre_3", {16'h0, bcd_o}, 32'h0);
    cyc();
    chk("clear_pre_4", {16'h0, bcd_o}, 32'h1);

    // Count to 0012 and watch the scan
    cyc(44);
    chk("at_12", {16'h0, bcd_o}, 32'h12);
    run = 1'b0;
    cyc(12);

    // Up to 41, then reset mid-run
    run = 1'b1;
    cyc(116);
    chk("at_41", {16'h0, bcd_o}, 32'h41);
    reset = 1'b1;
    cyc();
    chk("mid_reset_A",   {28'h0, a_o},   32'hF);
    chk("mid_reset_C",   {25'h0, c_o},   32'h7F);
    chk("mid_reset_bcd", {16'h0, bcd_o}, 32'h0);
    reset = 1'b0;
    cyc();
    chk("restart_A", {28'h0, a_o}, 32'hE);
    chk("restart_C", {25'h0, c_o}, 32'h40);
    cyc(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
